// File: rtl/commit_trace_if.sv
// Commit-stage to trace/difftest channel. The master side is the environment
// (core commit port plus trace consumer); the slave side is the controller.
interface commit_trace_if #(
    parameter int XLEN = 64
);
    logic            commit_valid;
    logic            commit_ready;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_inst;
    logic            commit_skip;
    logic            commit_ebreak;
    logic [XLEN-1:0] commit_a0;
    logic            trace_valid;
    logic            trace_ready;
    logic [XLEN-1:0] trace_pc;
    logic [63:0]     trace_inst;
    logic            trace_skip;
    logic            trace_ebreak;
    logic [63:0]     retired;
    logic            halted;
    logic [31:0]     halt_code;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_skip, commit_ebreak, commit_a0,
        output trace_ready,
        input  commit_ready, trace_valid, trace_pc, trace_inst, trace_skip, trace_ebreak,
        input  retired, halted, halt_code
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_skip, commit_ebreak, commit_a0,
        input  trace_ready,
        output commit_ready, trace_valid, trace_pc, trace_inst, trace_skip, trace_ebreak,
        output retired, halted, halt_code
    );
endinterface

// File: rtl/commit_trace_ctrl.sv
// Commit trace controller: queues retired-instruction reports in a small FIFO,
// hands them to the trace consumer one per handshake, and on ebreak drains the
// queue before latching the halt code and parking in HALT until reset.
module commit_trace_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input logic          clk,
    input logic          rst,
    commit_trace_if.slave intf
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            skip;
        logic            ebreak;
        logic [31:0]     a0;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      retired_q, retired_d;
    logic             halted_q, halted_d;
    logic [31:0]      halt_code_q, halt_code_d;

    entry_t head;
    logic   commit_ready;
    logic   trace_valid;
    logic   push;
    logic   pop;

    // Handshake qualifiers; both ready and valid depend only on registered state
    always_comb begin
        head         = mem_q[rd_ptr_q];
        commit_ready = (state_q == ST_RUN) && (count_q < FULL_CNT);
        trace_valid  = (count_q != '0) && (state_q != ST_HALT);
        push         = intf.commit_valid && commit_ready;
        pop          = trace_valid && intf.trace_ready;
    end

    // Next-state logic for the FIFO, the counters and the RUN/DRAIN/HALT FSM
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        retired_d   = retired_q;
        halted_d    = halted_q;
        halt_code_d = halt_code_q;

        if (push) begin
            mem_d[wr_ptr_q].pc     = intf.commit_pc;
            mem_d[wr_ptr_q].inst   = intf.commit_inst;
            mem_d[wr_ptr_q].skip   = intf.commit_skip;
            mem_d[wr_ptr_q].ebreak = intf.commit_ebreak;
            mem_d[wr_ptr_q].a0     = intf.commit_a0[31:0];
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            retired_d = retired_q + 64'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (push && intf.commit_ebreak) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Nothing is queued behind the ebreak, so popping it empties the FIFO
                if (pop && head.ebreak) begin
                    state_d     = ST_HALT;
                    halted_d    = 1'b1;
                    halt_code_d = head.a0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Control and status registers; all return to their idle values on reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            retired_q   <= '0;
            halted_q    <= 1'b0;
            halt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            retired_q   <= retired_d;
            halted_q    <= halted_d;
            halt_code_q <= halt_code_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q decides which slots are live and outputs are gated by trace_valid.
        mem_q <= mem_d;
    end

    // Upper a0 bits never reach the halt code
    if (XLEN > 32) begin : g_a0_hi
        logic unused_a0_hi;
        assign unused_a0_hi = ^intf.commit_a0[XLEN-1:32];
    end

    // Output drive; report fields read as zero whenever no report is offered
    assign intf.commit_ready  = commit_ready;
    assign intf.trace_valid   = trace_valid;
    assign intf.trace_pc      = trace_valid ? head.pc : '0;
    assign intf.trace_inst    = trace_valid ? {32'd0, head.inst} : 64'd0;
    assign intf.trace_skip    = trace_valid & head.skip;
    assign intf.trace_ebreak  = trace_valid & head.ebreak;
    assign intf.retired       = retired_q;
    assign intf.halted        = halted_q;
    assign intf.halt_code     = halt_code_q;

endmodule
